iq_sample_packer: RTL



---
 rtl/iq_sample_packer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/iq_sample_packer.sv
// Packs I/Q sample pairs two-per-word into the A2F FIFO, with a header word every FRAME_WORDS data words.
// Latency: the second sample of a pair in cycle N gives a registered fifo_wr/fifo_wdata in cycle N+1.
// Backpressure: headers wait while fifo_afull=1; data words completing under fifo_afull=1 are dropped and counted.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   enable              streaming enable; low returns to IDLE and discards a half-built word
//   s_valid, s_i, s_q   one I/Q pair per cycle when s_valid=1
//   fifo_afull          FIFO has at most one free slot
//   fifo_wr, fifo_wdata registered write strobe and word to the FIFO
//   drop_cnt, overflow  saturating dropped-word count and sticky drop flag
//   ovf_clr             clears drop_cnt and overflow (a simultaneous drop wins)
//
// Header word layout: {8'hA5, ovf_pending, 7'b0, frame_cnt[15:0]}.
// FT_DATA_WIDTH must equal 4*SAMPLE_WIDTH; FRAME_WORDS must be at least 2.

module iq_sample_packer #(
    parameter int SAMPLE_WIDTH  = 8,
    parameter int FT_DATA_WIDTH = 32,
    parameter int FRAME_WORDS   = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     s_valid,
    input  logic [SAMPLE_WIDTH-1:0]  s_i,
    input  logic [SAMPLE_WIDTH-1:0]  s_q,
    input  logic                     fifo_afull,
    output logic                     fifo_wr,
    output logic [FT_DATA_WIDTH-1:0] fifo_wdata,
    output logic [15:0]              drop_cnt,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int WCW = $clog2(FRAME_WORDS);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [15:0]                frame_cnt_q, frame_cnt_d;
    logic [WCW-1:0]             word_cnt_q, word_cnt_d;
    logic                       half_q, half_d;
    logic [2*SAMPLE_WIDTH-1:0]  held_q, held_d;       // {q, i} of the first sample of a pair
    logic                       ovf_pending_q, ovf_pending_d;
    logic                       wr_q, wr_d;
    logic [FT_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [15:0]                drop_cnt_q, drop_cnt_d;
    logic                       overflow_q, overflow_d;
    logic                       drop_now;

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        word_cnt_d    = word_cnt_q;
        half_d        = half_q;
        held_d        = held_q;
        ovf_pending_d = ovf_pending_q;
        wr_d          = 1'b0;
        wdata_d       = wdata_q;
        drop_cnt_d    = drop_cnt_q;
        overflow_d    = overflow_q;
        drop_now      = 1'b0;

        case (state_q)
            S_IDLE: begin
                half_d = 1'b0;
                if (enable) begin
                    state_d = S_HDR;
                end
            end

            S_HDR: begin
                // Samples arriving here are lost on purpose; the header owns this slot.
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (!fifo_afull) begin
                    wr_d          = 1'b1;
                    wdata_d       = FT_DATA_WIDTH'({8'hA5, ovf_pending_q, 7'b0, frame_cnt_q});
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                    ovf_pending_d = 1'b0;
                    word_cnt_d    = '0;
                    half_d        = 1'b0;
                    state_d       = S_DATA;
                end
            end

            S_DATA: begin
                if (!enable) begin
                    half_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (s_valid) begin
                    if (!half_q) begin
                        held_d = {s_q, s_i};
                        half_d = 1'b1;
                    end else begin
                        // Word slot is consumed whether written or dropped, so the
                        // frame length stays fixed in sample time.
                        half_d     = 1'b0;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (fifo_afull) begin
                            drop_now      = 1'b1;
                            ovf_pending_d = 1'b1;
                        end else begin
                            wr_d    = 1'b1;
                            wdata_d = {s_q, s_i, held_q};
                        end
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = S_HDR;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A drop in the same cycle as a clear leaves a count of one.
        if (drop_now) begin
            overflow_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            frame_cnt_q   <= 16'd0;
            word_cnt_q    <= '0;
            half_q        <= 1'b0;
            held_q        <= '0;
            ovf_pending_q <= 1'b0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            drop_cnt_q    <= 16'd0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            word_cnt_q    <= word_cnt_d;
            half_q        <= half_d;
            held_q        <= held_d;
            ovf_pending_q <= ovf_pending_d;
            wr_q          <= wr_d;
            wdata_q       <= wdata_d;
            drop_cnt_q    <= drop_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    assign fifo_wr    = wr_q;
    assign fifo_wdata = wdata_q;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;

endmodule
